// File: rtl/iod_pause_seq_pkg.sv
// Shared state encoding and default timing for the IOD pause/delay-update sequencer.
package iod_pause_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_MOVE = 3'd2,
        ST_GAP  = 3'd3,
        ST_POST = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    localparam int unsigned PRE_WAIT_DEF  = 4;
    localparam int unsigned MOVE_GAP_DEF  = 2;
    localparam int unsigned POST_WAIT_DEF = 4;

    function automatic logic is_pause_state(input state_t s);
        return (s == ST_PRE) || (s == ST_MOVE) || (s == ST_GAP) || (s == ST_POST);
    endfunction

endpackage

// File: rtl/iod_pause_seq_wait_cnt.sv
// Loadable 8-bit down-counter; tc flags the last cycle of a wait loaded with (length-1).
module iod_pause_seq_wait_cnt (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       tc
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == 8'd0);

endmodule

// File: rtl/iod_pause_seq.sv
// Pauses the high-speed IO clock around a burst of IOD delay tap moves.
// state | meaning: IDLE wait REQ, PRE pause settle, MOVE strobe, GAP inter-move idle, POST pause hold, FIN done pulse
module iod_pause_seq
    import iod_pause_seq_pkg::*;
#(
    parameter int unsigned PRE_WAIT  = PRE_WAIT_DEF,
    parameter int unsigned MOVE_GAP  = MOVE_GAP_DEF,
    parameter int unsigned POST_WAIT = POST_WAIT_DEF
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ,
    input  logic       DIR,
    input  logic [7:0] TAPS,
    input  logic       DELAY_OOR,
    output logic       HS_IO_CLK_PAUSE,
    output logic       DELAY_MOVE,
    output logic       DELAY_DIRECTION,
    output logic       BUSY,
    output logic       DONE,
    output logic       OOR_FLAG,
    output logic [7:0] MOVES_DONE
);

    localparam logic [7:0] PRE_LD  = 8'(PRE_WAIT - 1);
    localparam logic [7:0] GAP_LD  = (MOVE_GAP == 0) ? 8'd0 : 8'(MOVE_GAP - 1);
    localparam logic [7:0] POST_LD = 8'(POST_WAIT - 1);

    state_t     state_q, state_d;
    logic [7:0] rem_q, rem_d;
    logic [7:0] md_q, md_d;
    logic       dir_q, dir_d;
    logic       oor_q, oor_d;
    logic       pause_q, pause_d;
    logic       move;
    logic       wait_load;
    logic [7:0] wait_val;
    logic       wait_tc;

    iod_pause_seq_wait_cnt u_wait_cnt (
        .CLK      (CLK),
        .RESET    (RESET),
        .load     (wait_load),
        .load_val (wait_val),
        .tc       (wait_tc)
    );

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        md_d      = md_q;
        dir_d     = dir_q;
        oor_d     = oor_q;
        move      = 1'b0;
        wait_load = 1'b0;
        wait_val  = PRE_LD;
        case (state_q)
            ST_IDLE: begin
                if (REQ) begin
                    md_d  = 8'd0;
                    oor_d = 1'b0;
                    if (TAPS != 8'd0) begin
                        dir_d     = DIR;
                        rem_d     = TAPS;
                        wait_load = 1'b1;
                        wait_val  = PRE_LD;
                        state_d   = ST_PRE;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_PRE: begin
                if (wait_tc) state_d = ST_MOVE;
            end
            ST_MOVE: begin
                move  = ~DELAY_OOR;
                rem_d = rem_q - 8'd1;
                if (move) md_d = md_q + 8'd1;
                // Out-of-range wins over any remaining taps: go straight to the post-pause hold.
                if (DELAY_OOR || rem_q == 8'd1) begin
                    oor_d     = oor_q | DELAY_OOR;
                    wait_load = 1'b1;
                    wait_val  = POST_LD;
                    state_d   = ST_POST;
                end else if (MOVE_GAP == 0) begin
                    state_d = ST_MOVE;
                end else begin
                    wait_load = 1'b1;
                    wait_val  = GAP_LD;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (DELAY_OOR) begin
                    oor_d     = 1'b1;
                    wait_load = 1'b1;
                    wait_val  = POST_LD;
                    state_d   = ST_POST;
                end else if (wait_tc) begin
                    state_d = ST_MOVE;
                end
            end
            ST_POST: begin
                if (wait_tc) state_d = ST_FIN;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        pause_d = is_pause_state(state_d);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            rem_q   <= 8'd0;
            md_q    <= 8'd0;
            dir_q   <= 1'b0;
            oor_q   <= 1'b0;
            pause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            md_q    <= md_d;
            dir_q   <= dir_d;
            oor_q   <= oor_d;
            pause_q <= pause_d;
        end
    end

    assign HS_IO_CLK_PAUSE = pause_q;
    assign DELAY_MOVE      = move;
    assign DELAY_DIRECTION = dir_q;
    assign BUSY            = (state_q != ST_IDLE);
    assign DONE            = (state_q == ST_FIN);
    assign OOR_FLAG        = oor_q;
    assign MOVES_DONE      = md_q;

endmodule
